// File: rtl/grf_w_writeback_if.sv
// W-stage write-back / D-stage read bundle for the general register file.
interface grf_w_writeback_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
);
  logic                  W_RegWrite;
  logic [DEPTH_LOG2-1:0] W_Wreg;
  logic [WIDTH-1:0]      W_WD;
  logic [31:0]           W_PC;
  logic [DEPTH_LOG2-1:0] D_A1;
  logic [DEPTH_LOG2-1:0] D_A2;
  logic [WIDTH-1:0]      D_RD1;
  logic [WIDTH-1:0]      D_RD2;

  // Pipeline side: drives write-back and read addresses, consumes read data.
  modport master (
    output W_RegWrite, W_Wreg, W_WD, W_PC, D_A1, D_A2,
    input  D_RD1, D_RD2
  );

  // Register file side.
  modport slave (
    input  W_RegWrite, W_Wreg, W_WD, W_PC, D_A1, D_A2,
    output D_RD1, D_RD2
  );
endinterface

// File: rtl/grf_w_writeback.sv
// General register file: 2^DEPTH_LOG2 x WIDTH, $0 hardwired to zero,
// synchronous write from W, two combinational D read ports with W->D bypass.
// Optional feature macro: GRF_WRITE_TRACE_EN (prints a line per W write).
module grf_w_writeback #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  grf_w_writeback_if.slave bus
);

  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  // $0 has no storage; it always reads as zero.
  logic [WIDTH-1:0] rf [1:DEPTH-1];

  logic wr_en;
  assign wr_en = bus.W_RegWrite && (bus.W_Wreg != '0);

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[bus.W_Wreg] <= bus.W_WD;
    end
  end

  // Read port 1: zero on $0 or in reset, bypass a same-cycle W write, else storage.
  always_comb begin
    bus.D_RD1 = '0;
    if (reset_n && (bus.D_A1 != '0)) begin
      if (bus.W_RegWrite && (bus.W_Wreg == bus.D_A1)) begin
        bus.D_RD1 = bus.W_WD;
      end else begin
        bus.D_RD1 = rf[bus.D_A1];
      end
    end
  end

  // Read port 2: same rules as port 1, independently addressed.
  always_comb begin
    bus.D_RD2 = '0;
    if (reset_n && (bus.D_A2 != '0)) begin
      if (bus.W_RegWrite && (bus.W_Wreg == bus.D_A2)) begin
        bus.D_RD2 = bus.W_WD;
      end else begin
        bus.D_RD2 = rf[bus.D_A2];
      end
    end
  end

`ifdef GRF_WRITE_TRACE_EN
  // Write trace; $0 writes are shown too even though storage ignores them.
  always @(posedge clk) begin
    if (reset_n && bus.W_RegWrite) begin
      $display("@%08h: $%2d <= %08h", bus.W_PC, bus.W_Wreg, bus.W_WD);
    end
  end
`else
  // W_PC only feeds the trace.
  logic unused_pc;
  assign unused_pc = ^bus.W_PC;
`endif

endmodule

// File: tb/tb_grf_w_writeback.sv
// Bench for grf_w_writeback: directed vectors with literal expectations plus a
// per-cycle comparison against an array model of the register file.
`timescale 1ns/1ps
module tb_grf_w_writeback;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  grf_w_writeback_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus ();

  grf_w_writeback #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 32 plain words, $0 kept at zero by never writing it.
  logic [31:0] mrf [32];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    end else if (bus.W_RegWrite && bus.W_Wreg != 5'd0) begin
      mrf[bus.W_Wreg] = bus.W_WD;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!reset_n || a == 5'd0) return 32'h0;
    if (bus.W_RegWrite && bus.W_Wreg == a) return bus.W_WD;
    return mrf[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison, sampled on the falling edge.
  always @(negedge clk) begin
    chk("model_rd1", bus.D_RD1, model_read(bus.D_A1));
    chk("model_rd2", bus.D_RD2, model_read(bus.D_A2));
  end

  // Advance to 2ns after the next rising edge, the point where inputs change.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.W_RegWrite = we;
    bus.W_Wreg     = wreg;
    bus.W_WD       = wd;
    bus.W_PC       = 32'h0040_0000 + {25'd0, wreg, 2'b00};
    bus.D_A1       = a1;
    bus.D_A2       = a2;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Held in reset: every address reads zero, writes ignored.
    for (int i = 0; i < 32; i++) begin
      step();
      drive(1'b1, 5'(i), 32'hA5A5_0000 | i, 5'(i), 5'(31 - i));
      #1;
      chk("rst_sweep_rd1", bus.D_RD1, 32'h0);
      chk("rst_sweep_rd2", bus.D_RD2, 32'h0);
    end

    // Released, no writes: still all zero.
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      chk("post_rst_rd1", bus.D_RD1, 32'h0);
      chk("post_rst_rd2", bus.D_RD2, 32'h0);
    end

    // Write $5 then read it back from storage.
    step();
    drive(1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    #1;
    chk("wr_rd_5", bus.D_RD1, 32'h1234_5678);
    chk("wr_rd_1", bus.D_RD2, 32'h0);

    // Same-cycle bypass on both ports, then from storage.
    step();
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8);
    #1;
    chk("byp_rd1", bus.D_RD1, 32'hDEAD_BEEF);
    chk("byp_rd2", bus.D_RD2, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    #1;
    chk("stored_rd1", bus.D_RD1, 32'hDEAD_BEEF);
    chk("stored_rd2", bus.D_RD2, 32'hDEAD_BEEF);

    // $0 never bypasses and never stores.
    step();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    chk("zero_before", bus.D_RD1, 32'h0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    chk("zero_after", bus.D_RD1, 32'h0);

    // Port independence: only the matching port bypasses.
    step();
    drive(1'b1, 5'd3, 32'h3, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd4, 32'h4, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd3, 32'hAA, 5'd3, 5'd4);
    #1;
    chk("indep_rd1", bus.D_RD1, 32'hAA);
    chk("indep_rd2", bus.D_RD2, 32'h4);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd8);
    #1;
    chk("indep_after_rd1", bus.D_RD1, 32'hAA);
    chk("indep_after_rd2", bus.D_RD2, 32'hDEAD_BEEF);

    // Fill $1..$31 with their own index.
    for (int i = 1; i < 32; i++) begin
      step();
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
    #1;
    chk("fill_rd9", bus.D_RD1, 32'd9);
    chk("fill_rd31", bus.D_RD2, 32'd31);

    // Async reset pulse between edges clears everything immediately.
    step();
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd9", bus.D_RD1, 32'h0);
    chk("async_rst_rd31", bus.D_RD2, 32'h0);
    reset_n = 1'b1;
    #0.5;
    chk("after_pulse_rd9", bus.D_RD1, 32'h0);
    chk("after_pulse_rd31", bus.D_RD2, 32'h0);

    // Reset overlapping a write edge: the write is lost.
    step();
    drive(1'b1, 5'd10, 32'h5555_5555, 5'd10, 5'd10);
    reset_n = 1'b0;
    #1;
    chk("rst_write_byp", bus.D_RD1, 32'h0);
    step();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd5);
    #1;
    chk("rst_write_lost", bus.D_RD1, 32'h0);
    chk("rst_cleared_5", bus.D_RD2, 32'h0);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] w;
      w = 5'($urandom_range(0, 31));
      step();
      drive(1'($urandom_range(0, 1)), w, $urandom,
            (i % 3 == 0) ? w : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
